// File: rtl/msxbus_pkg.sv
// Shared definitions for the MSX bus transaction sequencer: timing constants,
// host op codes, control-word bit positions, FSM states and word builders.
package msxbus_pkg;

    localparam int T_SETUP  = 4;
    localparam int T_STROBE = 48;
    localparam int T_RESET  = 256;
    localparam int WAIT_MAX = 4096;

    localparam int CNT_W = 9;
    localparam int EXT_W = 13;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(T_RESET - 1);
    localparam logic [EXT_W-1:0] EXT_LIMIT   = EXT_W'(WAIT_MAX);

    localparam logic [2:0] OP_MRD   = 3'b000;
    localparam logic [2:0] OP_MWR   = 3'b001;
    localparam logic [2:0] OP_IORD  = 3'b010;
    localparam logic [2:0] OP_IOWR  = 3'b011;
    localparam logic [2:0] OP_FETCH = 3'b100;
    localparam logic [2:0] OP_RESET = 3'b101;

    localparam int CW_RD_N    = 15;
    localparam int CW_WR_N    = 14;
    localparam int CW_MREQ_N  = 13;
    localparam int CW_IORQ_N  = 12;
    localparam int CW_SLOT_HI = 11;
    localparam int CW_SLOT_LO = 10;
    localparam int CW_RESET_N = 9;
    localparam int CW_M1_N    = 8;

    // All strobes released, slot 11, no write data.
    localparam logic [15:0] IDLE_WORD  = 16'hFFFF;
    // Idle word with only the bus reset line pulled low.
    localparam logic [15:0] RESET_WORD = IDLE_WORD ^ (16'h0001 << CW_RESET_N);

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_IDLE    = 4'd1,
        ST_ADDR    = 4'd2,
        ST_SETUP   = 4'd3,
        ST_STROBE  = 4'd4,
        ST_HOLD    = 4'd5,
        ST_SAMPLE  = 4'd6,
        ST_RELEASE = 4'd7,
        ST_RSTHOLD = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_RESET);
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_MRD) || (op == OP_IORD) || (op == OP_FETCH);
    endfunction

    // Builds the strobe word for a bus cycle: unused strobes stay released.
    function automatic logic [15:0] ctrl_word(input logic [2:0] op,
                                              input logic [1:0] slot,
                                              input logic [7:0] wdata);
        logic [15:0] w;
        w = IDLE_WORD;
        w[CW_SLOT_HI:CW_SLOT_LO] = slot;
        w[7:0] = wdata;
        case (op)
            OP_MRD:   begin w[CW_RD_N] = 1'b0; w[CW_MREQ_N] = 1'b0; end
            OP_MWR:   begin w[CW_WR_N] = 1'b0; w[CW_MREQ_N] = 1'b0; end
            OP_IORD:  begin w[CW_RD_N] = 1'b0; w[CW_IORQ_N] = 1'b0; end
            OP_IOWR:  begin w[CW_WR_N] = 1'b0; w[CW_IORQ_N] = 1'b0; end
            OP_FETCH: begin w[CW_RD_N] = 1'b0; w[CW_MREQ_N] = 1'b0; w[CW_M1_N] = 1'b0; end
            default:  begin w = IDLE_WORD; end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/msx_sync2.sv
// Two-flop synchronizer for the asynchronous MSX WAIT line; idles high.
module msx_sync2
    import msxbus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Capture the asynchronous input through two stages, resetting to released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/msxbus_seq.sv
// MSX bus transaction sequencer: turns one host request at a time into an
// address word plus timed control words for the bus I/O block, stretches the
// strobe phase on WAIT, captures read data and reports completion.
// All outputs are registered and decoded from the next state, so they line up
// with the state register cycle for cycle.
module msxbus_seq
    import msxbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [1:0]  slot,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        cs,
    output logic        a0,
    output logic [15:0] md_out,
    output logic        md_oe_hi,
    output logic        md_oe_lo,
    input  logic [15:0] md_in,
    input  logic        rwait
);
    state_t            state_r, state_nx;
    logic [CNT_W-1:0]  cnt_r, cnt_nx;
    logic [EXT_W-1:0]  ext_r, ext_nx;
    logic [2:0]        op_r, op_nx;
    logic [1:0]        slot_r, slot_nx;
    logic [15:0]       addr_r, addr_nx;
    logic [7:0]        wdata_r, wdata_nx;
    logic              err_flag_r, err_flag_nx;
    logic              init_done_r, init_done_nx;
    logic              rwait_s;

    logic              cs_nx, a0_nx, oe_hi_nx, oe_lo_nx, busy_nx, ack_nx, err_nx;
    logic [15:0]       md_nx;
    logic [7:0]        rdata_nx;

    // Only the low byte of the bus data carries read data.
    logic              unused_md_hi;
    assign unused_md_hi = ^md_in[15:8];

    msx_sync2 u_rwait_sync (
        .clk (clk),
        .rst (rst),
        .d   (rwait),
        .q   (rwait_s)
    );

    // Next-state, phase counters and request latch
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        ext_nx       = ext_r;
        op_nx        = op_r;
        slot_nx      = slot_r;
        addr_nx      = addr_r;
        wdata_nx     = wdata_r;
        err_flag_nx  = err_flag_r;
        init_done_nx = init_done_r;
        case (state_r)
            ST_INIT: begin
                // First INIT cycle issues the idle word, second moves on.
                if (init_done_r) begin
                    state_nx = ST_IDLE;
                end else begin
                    init_done_nx = 1'b1;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    op_nx       = op;
                    slot_nx     = slot;
                    addr_nx     = addr;
                    wdata_nx    = wdata;
                    cnt_nx      = {CNT_W{1'b0}};
                    ext_nx      = {EXT_W{1'b0}};
                    err_flag_nx = !op_is_legal(op);
                    if (!op_is_legal(op)) begin
                        state_nx = ST_DONE;
                    end else if (op == OP_RESET) begin
                        state_nx = ST_RSTHOLD;
                    end else begin
                        state_nx = ST_ADDR;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_nx = ST_SETUP;
                cnt_nx   = {CNT_W{1'b0}};
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_nx = ST_STROBE;
                end else begin
                    cnt_nx = cnt_r + 1'b1;
                end
            end
            ST_STROBE: begin
                state_nx = ST_HOLD;
                cnt_nx   = {CNT_W{1'b0}};
                ext_nx   = {EXT_W{1'b0}};
            end
            ST_HOLD: begin
                // Minimum strobe width first, then stretch while WAIT is low.
                if (cnt_r != STROBE_LAST) begin
                    cnt_nx = cnt_r + 1'b1;
                end else if (rwait_s) begin
                    state_nx = op_is_read(op_r) ? ST_SAMPLE : ST_RELEASE;
                end else if (ext_r == EXT_LIMIT) begin
                    state_nx    = ST_RELEASE;
                    err_flag_nx = 1'b1;
                end else begin
                    ext_nx = ext_r + 1'b1;
                end
            end
            ST_SAMPLE: begin
                state_nx = ST_RELEASE;
            end
            ST_RSTHOLD: begin
                if (cnt_r == RESET_LAST) begin
                    state_nx = ST_RELEASE;
                end else begin
                    cnt_nx = cnt_r + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_INIT;
            end
        endcase
    end

    // Output values for the cycle about to start, decoded from the next state
    always_comb begin
        cs_nx    = 1'b1;
        a0_nx    = a0;
        md_nx    = md_out;
        oe_hi_nx = 1'b1;
        oe_lo_nx = 1'b1;
        busy_nx  = 1'b1;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        case (state_nx)
            ST_INIT: begin
                cs_nx = 1'b0;
                a0_nx = 1'b1;
                md_nx = IDLE_WORD;
            end
            ST_IDLE: begin
                busy_nx = 1'b0;
            end
            ST_ADDR: begin
                cs_nx = 1'b0;
                a0_nx = 1'b0;
                md_nx = addr_nx;
            end
            ST_STROBE: begin
                cs_nx = 1'b0;
                a0_nx = 1'b1;
                md_nx = ctrl_word(op_r, slot_r, wdata_r);
            end
            ST_SAMPLE: begin
                cs_nx    = 1'b0;
                a0_nx    = 1'b1;
                md_nx    = ctrl_word(op_r, slot_r, wdata_r);
                oe_lo_nx = 1'b0;
            end
            ST_RELEASE: begin
                cs_nx = 1'b0;
                a0_nx = 1'b1;
                md_nx = IDLE_WORD;
            end
            ST_RSTHOLD: begin
                // Only the entry cycle writes the reset word; it then stays latched.
                if (state_r == ST_IDLE) begin
                    cs_nx = 1'b0;
                    a0_nx = 1'b1;
                    md_nx = RESET_WORD;
                end else begin
                    cs_nx = 1'b1;
                end
            end
            ST_DONE: begin
                ack_nx = 1'b1;
                err_nx = err_flag_nx;
            end
            default: begin
                cs_nx = 1'b1;
            end
        endcase
        if (state_r == ST_SAMPLE) begin
            rdata_nx = md_in[7:0];
        end else begin
            rdata_nx = rdata;
        end
    end

    // Sequencer state and latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_INIT;
            cnt_r       <= {CNT_W{1'b0}};
            ext_r       <= {EXT_W{1'b0}};
            op_r        <= 3'b000;
            slot_r      <= 2'b00;
            addr_r      <= 16'h0000;
            wdata_r     <= 8'h00;
            err_flag_r  <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            ext_r       <= ext_nx;
            op_r        <= op_nx;
            slot_r      <= slot_nx;
            addr_r      <= addr_nx;
            wdata_r     <= wdata_nx;
            err_flag_r  <= err_flag_nx;
            init_done_r <= init_done_nx;
        end
    end

    // Registered outputs; reset releases the bus block immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs       <= 1'b1;
            a0       <= 1'b0;
            md_out   <= 16'h0000;
            md_oe_hi <= 1'b0;
            md_oe_lo <= 1'b0;
            busy     <= 1'b1;
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            cs       <= cs_nx;
            a0       <= a0_nx;
            md_out   <= md_nx;
            md_oe_hi <= oe_hi_nx;
            md_oe_lo <= oe_lo_nx;
            busy     <= busy_nx;
            ack      <= ack_nx;
            err      <= err_nx;
            rdata    <= rdata_nx;
        end
    end
endmodule

// File: tb/tb_msxbus_seq.sv
// Self-checking bench for msxbus_seq. A timeline model derives, for each
// request, which cycles must carry a bus word, which word, and when ack lands.
module tb_msxbus_seq;

    localparam int TS        = 4;
    localparam int TSTR      = 48;
    localparam int TR        = 256;
    localparam int WMAX      = 4096;
    localparam int STROBE_C  = 2 + TS;          // cycle of the strobe word
    localparam int HOLD_LAST = 2 + TS + TSTR;   // last minimum-width hold cycle

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [1:0]  slot = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [15:0] md_in = 16'h0000;
    logic        rwait = 1'b1;
    logic        busy, ack, err, cs, a0, md_oe_hi, md_oe_lo;
    logic [7:0]  rdata;
    logic [15:0] md_out;

    int checks = 0;
    int errors = 0;
    int lo_a = 1;
    int lo_b = 0;
    logic [7:0] exp_rdata = 8'h00;

    msxbus_seq dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .slot(slot), .addr(addr),
        .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .cs(cs), .a0(a0), .md_out(md_out), .md_oe_hi(md_oe_hi),
        .md_oe_lo(md_oe_lo), .md_in(md_in), .rwait(rwait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raw WAIT level in transaction cycle c (low inside [lo_a, lo_b]).
    function automatic logic raw_rw(input int c);
        return !(c >= lo_a && c <= lo_b);
    endfunction

    // Control word from the field definitions.
    function automatic logic [15:0] model_cw(input logic [2:0] o, input logic [1:0] s,
                                             input logic [7:0] w);
        logic rd, wr, mem, io, m1;
        rd  = (o == 3'd0) || (o == 3'd2) || (o == 3'd4);
        wr  = (o == 3'd1) || (o == 3'd3);
        mem = (o == 3'd0) || (o == 3'd1) || (o == 3'd4);
        io  = (o == 3'd2) || (o == 3'd3);
        m1  = (o == 3'd4);
        return {~rd, ~wr, ~mem, ~io, s, 1'b1, ~m1, w};
    endfunction

    task automatic await_idle(input string tag);
        for (int i = 0; i < 8 && busy !== 1'b0; i++) step();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic after_reset(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (cs === 1'b0) seen = 1'b1;
        end
        chk({tag, "_init_cs"}, 32'(seen), 32'd1);
        chk({tag, "_init_word"}, 32'(md_out), 32'hFFFF);
        chk({tag, "_init_a0"}, 32'(a0), 32'd1);
        chk({tag, "_init_oe"}, 32'({md_oe_hi, md_oe_lo}), 32'd3);
        chk({tag, "_init_ack"}, 32'(ack), 32'd0);
        await_idle(tag);
        chk({tag, "_idle_cs"}, 32'(cs), 32'd1);
    endtask

    task automatic run_txn(input string tag, input logic [2:0] o, input logic [1:0] s,
                           input logic [15:0] a, input logic [7:0] w, input logic [15:0] mi);
        int ev_c[4];
        logic [15:0] ev_w[4];
        logic ev_a0[4];
        logic ev_lo[4];
        int n_ev, ack_c, d, rel;
        logic legal, rd, to, exp_err, low, a0_e, lo_e;
        logic [15:0] w_e, cw;
        logic [7:0] rd_e;
        legal = (o <= 3'd5);
        rd    = (o == 3'd0) || (o == 3'd2) || (o == 3'd4);
        to    = 1'b0;
        n_ev  = 0;
        cw    = model_cw(o, s, w);
        if (!legal) begin
            ack_c = 1;
        end else if (o == 3'd5) begin
            ev_c[0] = 1;      ev_w[0] = 16'hFDFF; ev_a0[0] = 1'b1; ev_lo[0] = 1'b1;
            ev_c[1] = TR + 1; ev_w[1] = 16'hFFFF; ev_a0[1] = 1'b1; ev_lo[1] = 1'b1;
            n_ev  = 2;
            ack_c = TR + 2;
        end else begin
            to = 1'b1;
            d  = HOLD_LAST + WMAX;
            for (int c = HOLD_LAST; c <= HOLD_LAST + WMAX; c++) begin
                if (raw_rw(c - 2)) begin
                    d  = c;
                    to = 1'b0;
                    break;
                end
            end
            ev_c[0] = 1;        ev_w[0] = a;  ev_a0[0] = 1'b0; ev_lo[0] = 1'b1;
            ev_c[1] = STROBE_C; ev_w[1] = cw; ev_a0[1] = 1'b1; ev_lo[1] = 1'b1;
            n_ev = 2;
            if (rd && !to) begin
                ev_c[2] = d + 1; ev_w[2] = cw; ev_a0[2] = 1'b1; ev_lo[2] = 1'b0;
                n_ev = 3;
                rel = d + 2;
            end else begin
                rel = d + 1;
            end
            ev_c[n_ev] = rel; ev_w[n_ev] = 16'hFFFF; ev_a0[n_ev] = 1'b1; ev_lo[n_ev] = 1'b1;
            n_ev++;
            ack_c = rel + 1;
        end
        exp_err = !legal || to;
        rd_e = (legal && rd && !to) ? mi[7:0] : exp_rdata;

        await_idle(tag);
        req = 1'b1; op = o; slot = s; addr = a; wdata = w; md_in = mi;
        rwait = raw_rw(0);
        for (int c = 1; c <= ack_c + 1; c++) begin
            step();
            req = (c == 3) || (c == ack_c);
            op  = 3'($urandom_range(0, 7));
            rwait = raw_rw(c);
            low = 1'b0; w_e = 16'h0000; a0_e = 1'b0; lo_e = 1'b1;
            for (int j = 0; j < n_ev; j++) begin
                if (ev_c[j] == c) begin
                    low = 1'b1; w_e = ev_w[j]; a0_e = ev_a0[j]; lo_e = ev_lo[j];
                end
            end
            chk($sformatf("%s_cs_c%0d", tag, c), 32'(cs), 32'(!low));
            if (low) begin
                chk($sformatf("%s_word_c%0d", tag, c), 32'(md_out), 32'(w_e));
                chk($sformatf("%s_a0_c%0d", tag, c), 32'(a0), 32'(a0_e));
            end
            chk($sformatf("%s_oelo_c%0d", tag, c), 32'(md_oe_lo), 32'(lo_e));
            chk($sformatf("%s_oehi_c%0d", tag, c), 32'(md_oe_hi), 32'd1);
            chk($sformatf("%s_ack_c%0d", tag, c), 32'(ack), 32'(c == ack_c));
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= ack_c));
            if (c == ack_c) begin
                chk({tag, "_err"}, 32'(err), 32'(exp_err));
                chk({tag, "_rdata"}, 32'(rdata), 32'(rd_e));
            end
        end
        req = 1'b0;
        rwait = 1'b1;
        exp_rdata = rd_e;
    endtask

    initial begin
        // Power-on reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_a0", 32'(a0), 32'd0);
        chk("rst_md", 32'(md_out), 32'd0);
        chk("rst_oe", 32'({md_oe_hi, md_oe_lo}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        after_reset("por");

        // Directed cases
        run_txn("mwr", 3'd1, 2'b01, 16'h4000, 8'hA5, 16'h0000);
        run_txn("iord", 3'd2, 2'b00, 16'h0098, 8'h00, 16'h123C);
        lo_a = HOLD_LAST - 2; lo_b = HOLD_LAST + 97;
        run_txn("mrd_wait", 3'd0, 2'b10, 16'h8001, 8'h00, 16'h0077);
        lo_a = 40; lo_b = 1000000;
        run_txn("mrd_tmo", 3'd0, 2'b11, 16'hC000, 8'h00, 16'h00EE);
        lo_a = 1; lo_b = 0;
        run_txn("illegal", 3'd7, 2'b00, 16'h0000, 8'h00, 16'h0000);
        run_txn("busrst", 3'd5, 2'b01, 16'h1234, 8'h55, 16'h0000);
        run_txn("fetch", 3'd4, 2'b10, 16'h0038, 8'h00, 16'h00C9);
        run_txn("iowr", 3'd3, 2'b11, 16'h00A0, 8'h5A, 16'h0000);

        // Reset in the middle of a HOLD phase
        await_idle("midrst");
        req = 1'b1; op = 3'd0; slot = 2'b00; addr = 16'h2222; md_in = 16'h0011;
        step();
        req = 1'b0;
        repeat (18) step();
        #3 rst = 1'b1;
        #1;
        chk("midrst_cs", 32'(cs), 32'd1);
        chk("midrst_oe", 32'({md_oe_hi, md_oe_lo}), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        step();
        step();
        chk("midrst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        exp_rdata = 8'h00;
        after_reset("midrst");
        run_txn("post_rst", 3'd1, 2'b10, 16'h5555, 8'h3C, 16'h0000);

        // Randomized requests with occasional WAIT windows around terminal count
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                lo_a = int'($urandom_range(40, 60));
                lo_b = lo_a + int'($urandom_range(0, 80));
            end else begin
                lo_a = 1;
                lo_b = 0;
            end
            run_txn($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    16'($urandom), 8'($urandom), 16'($urandom));
        end
        lo_a = 1;
        lo_b = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
